be8_bus_ctrl: RTL

Wait-state bus controller between the be8 core and its RAM/IO. It sits on the core's memory side and paces each access with a programmable number of wait states. It drives the core's `ready`, qualifies RAM writes into a single-cycle write enable, and decodes one memory-mapped I/O byte port. Its purpose is to let the core run against memories slower than one access per cycle.

---
 rtl/be8_bus_ctrl_pkg.sv | 25 ++
 rtl/be8_bus_ctrl_wait_counter.sv | 28 ++
 rtl/be8_bus_ctrl.sv | 128 ++++++++++++
 3 files changed

// File: rtl/be8_bus_ctrl_pkg.sv
// be8_bus_ctrl_pkg: shared types and constants for the be8 wait-state bus controller.
package be8_bus_ctrl_pkg;

    // Controller FSM states, in their fixed encoding.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    // Default address of the memory-mapped I/O byte port.
    localparam logic [7:0] IO_ADDR_DEFAULT = 8'hE0;

    // Access direction as presented on cpu_rw.
    localparam logic DIR_READ  = 1'b0;
    localparam logic DIR_WRITE = 1'b1;

    // One core access as latched at the start of a bus cycle.
    typedef struct packed {
        logic [7:0] addr;
        logic       rw;
        logic [7:0] wdata;
    } access_t;

endpackage

// File: rtl/be8_bus_ctrl_wait_counter.sv
// be8_bus_ctrl_wait_counter: loadable 4-bit down-counter that paces the wait states.
// hit flags the last wait cycle (count == 1); the count stops at zero.
module be8_bus_ctrl_wait_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic       hit
);

    logic [3:0] wcnt;

    // Load the wait-state budget at the start of an access, then count it down.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            wcnt <= 4'd0;
        end else if (load) begin
            wcnt <= load_val;
        end else if (dec && (wcnt != 4'd0)) begin
            wcnt <= wcnt - 4'd1;
        end
    end

    assign hit = (wcnt == 4'd1);

endmodule

// File: rtl/be8_bus_ctrl.sv
// be8_bus_ctrl: wait-state bus controller between the be8 core and its RAM / I/O byte port.
// Every access runs IDLE -> WAIT x WAIT_CYCLES -> DONE; ready, mem_we and io_strobe are
// registered so they are high exactly during the DONE cycle.
module be8_bus_ctrl
    import be8_bus_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 2,               // 0..15 wait states per access
    parameter logic [7:0]  IO_ADDR     = IO_ADDR_DEFAULT   // address of the I/O byte port
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] cpu_addr,
    input  logic       cpu_rw,
    input  logic [7:0] cpu_wdata,
    output logic [7:0] cpu_rdata,
    output logic       ready,
    output logic [7:0] mem_addr,
    output logic       mem_we,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata,
    input  logic [7:0] io_in,
    output logic [7:0] io_out,
    output logic       io_strobe
);

    // Only the low four bits are meaningful; the counter is 4 bits wide.
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    state_t     state;
    access_t    cap;
    logic       wcnt_hit;
    logic [7:0] acc_addr;
    logic       acc_rw;
    logic       abort;
    logic       go_done;

    // RAM only ever sees the captured access, so its address is stable through WAIT and DONE.
    assign mem_addr  = cap.addr;
    assign mem_wdata = cap.wdata;

    be8_bus_ctrl_wait_counter u_wait_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (state == IDLE),
        .load_val (WAIT_LOAD),
        .dec      (state == WAIT),
        .hit      (wcnt_hit)
    );

    // Decode the access about to finish, whether the core moved away from it, and whether DONE is next.
    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        acc_addr = cap.addr;
        acc_rw   = cap.rw;
        abort    = 1'b0;
        go_done  = 1'b0;
        case (state)
            IDLE: begin
                // With no wait states the access completes straight from IDLE, using the values being captured.
                acc_addr = cpu_addr;
                acc_rw   = cpu_rw;
                go_done  = (WAIT_LOAD == 4'd0);
            end
            WAIT: begin
                // A core that changes address or direction mid-access abandons it; this beats the last wait cycle.
                abort   = (cpu_addr != cap.addr) || (cpu_rw != cap.rw);
                go_done = wcnt_hit && !abort;
            end
            default: begin
            end
        endcase
    end

    // Controller FSM with capture registers, registered completion decodes, read data and I/O port.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cap       <= '0;
            ready     <= 1'b0;
            mem_we    <= 1'b0;
            io_strobe <= 1'b0;
            cpu_rdata <= 8'h00;
            io_out    <= 8'h00;
        end else begin
            ready     <= 1'b0;
            mem_we    <= 1'b0;
            io_strobe <= 1'b0;

            case (state)
                IDLE: begin
                    cap.addr  <= cpu_addr;
                    cap.rw    <= cpu_rw;
                    cap.wdata <= cpu_wdata;
                    state     <= go_done ? DONE : WAIT;
                end
                WAIT: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (go_done) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if ((cap.rw == DIR_WRITE) && (cap.addr == IO_ADDR)) begin
                        io_out <= cap.wdata;
                    end
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            // Outputs that are high during DONE are set on the edge that enters it.
            if (go_done) begin
                ready <= 1'b1;
                if (acc_rw == DIR_READ) begin
                    cpu_rdata <= (acc_addr == IO_ADDR) ? io_in : mem_rdata;
                end else if (acc_addr == IO_ADDR) begin
                    io_strobe <= 1'b1;
                end else begin
                    mem_we <= 1'b1;
                end
            end
        end
    end

endmodule
